// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request fields latched at arbitration time.
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the memory port arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [2:0]        ls_funct3;
  logic [DATA_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational RV32 load/store lane logic: byte enables, store replication,
// legality check and load extraction with sign/zero extension.
module lsu_byte_lane
  import mem_arb_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic              we,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic              err,
  output logic [DATA_W-1:0] load_data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    be        = '0;
    wdata_rep = '0;
    err       = 1'b0;
    load_data = '0;
    case (funct3)
      F3_B: begin
        be        = BE_W'(4'b0001 << addr_lo);
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        err       = addr_lo[0];
        be        = BE_W'(4'b0011 << addr_lo);
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        err       = |addr_lo;
        be        = '1;
        wdata_rep = wdata;
        load_data = shifted;
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        err       = we;
        load_data = {24'b0, shifted[7:0]};
      end
      F3_HU: begin
        err       = we | addr_lo[0];
        load_data = {16'b0, shifted[15:0]};
      end
      default: err = 1'b1;
    endcase
    if (!we) be = '1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store,
// one transaction in flight, with starvation-bounded LS priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
)(
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  req_t                req_q, req_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                err_q, err_d;

  logic [BE_W-1:0]     lane_be;
  logic [DATA_W-1:0]   lane_wdata;
  logic                lane_err;
  logic [DATA_W-1:0]   lane_load;
  logic                legal;
  logic                pick_if;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_q.addr[DATA_W-1:ADDR_W+2];

  lsu_byte_lane u_lane (
    .funct3    (req_q.funct3),
    .we        (req_q.we),
    .addr_lo   (req_q.addr[1:0]),
    .wdata     (req_q.wdata),
    .rdata     (bus.mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .err       (lane_err),
    .load_data (lane_load)
  );

  // IF fetches are always word accesses; legality only applies to LS.
  assign legal = (owner_q == OWN_IF) || !lane_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      req_q      <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    err_d      = err_q;
    pick_if    = 1'b0;

    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = if_rdata_q;
    bus.ls_gnt    = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = ls_rdata_q;
    bus.ls_err    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          pick_if = bus.if_req && (!bus.ls_req || (starve_q == STARVE_W'(STARVE_MAX)));
          if (pick_if) begin
            owner_d  = OWN_IF;
            req_d    = '{we: 1'b0, funct3: F3_W, addr: bus.if_addr, wdata: '0};
            starve_d = '0;
          end else begin
            owner_d  = OWN_LS;
            req_d    = '{we: bus.ls_we, funct3: bus.ls_funct3,
                         addr: bus.ls_addr, wdata: bus.ls_wdata};
            starve_d = bus.if_req ? starve_q + STARVE_W'(1) : '0;
          end
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.if_gnt = (owner_q == OWN_IF);
        bus.ls_gnt = (owner_q == OWN_LS);
        lat_d      = '0;
        if (legal) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = req_q.we;
          bus.mem_be    = (owner_q == OWN_IF) ? '1 : lane_be;
          bus.mem_addr  = req_q.addr[ADDR_W+1:2];
          bus.mem_wdata = req_q.we ? lane_wdata : '0;
          state_d       = WAIT;
        end else begin
          err_d      = 1'b1;
          ls_rdata_d = '0;
          state_d    = RESP;
        end
      end
      WAIT: begin
        // Read data is valid MEM_LAT cycles after the issue cycle.
        if (lat_q == LAT_W'(MEM_LAT - 1)) begin
          if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
          else                   ls_rdata_d = req_q.we ? '0 : lane_load;
          state_d = RESP;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RESP: begin
        bus.if_rvalid = (owner_q == OWN_IF);
        bus.ls_rvalid = (owner_q == OWN_LS);
        bus.ls_err    = (owner_q == OWN_LS) && err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: one arbiter with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) a ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) b ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk (clk), .rst (rst_a), .bus (a)
  );
  mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (b)
  );

  // RAM models with preload port
  logic [31:0] ram_a [1024];
  logic [31:0] ram_b [1024];
  logic [31:0] rd_a, pb0, pb1, pb2;
  logic        pl_a_en, pl_b_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_a_en) ram_a[pl_addr] <= pl_data;
    else if (a.mem_en && a.mem_we)
      for (int i = 0; i < 4; i++)
        if (a.mem_be[i]) ram_a[a.mem_addr][8*i +: 8] <= a.mem_wdata[8*i +: 8];
    rd_a <= (a.mem_en && !a.mem_we) ? ram_a[a.mem_addr] : 32'hBAD0_BAD0;
  end
  assign a.mem_rdata = rd_a;

  always @(posedge clk) begin
    if (pl_b_en) ram_b[pl_addr] <= pl_data;
    else if (b.mem_en && b.mem_we)
      for (int i = 0; i < 4; i++)
        if (b.mem_be[i]) ram_b[b.mem_addr][8*i +: 8] <= b.mem_wdata[8*i +: 8];
    pb0 <= (b.mem_en && !b.mem_we) ? ram_b[b.mem_addr] : 32'hBAD0_BAD0;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign b.mem_rdata = pb2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel_b, input logic [9:0] addr, input logic [31:0] data);
    pl_addr = addr;
    pl_data = data;
    pl_a_en = !sel_b;
    pl_b_en = sel_b;
    @(negedge clk);
    pl_a_en = 1'b0;
    pl_b_en = 1'b0;
  endtask

  // One LS transaction on the MEM_LAT=1 instance, checked at issue and response.
  task automatic ls_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int n;
    int en_seen;
    a.ls_req = 1'b1; a.ls_we = we; a.ls_funct3 = f3; a.ls_addr = addr; a.ls_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!a.ls_gnt && n < 20) begin @(negedge clk); n++; end
    check({tag, ".gnt"}, a.ls_gnt, 1);
    check({tag, ".mem_en"}, a.mem_en, !exp_err);
    if (!exp_err) begin
      check({tag, ".mem_we"}, a.mem_we, we);
      check({tag, ".mem_be"}, a.mem_be, exp_be);
      check({tag, ".mem_addr"}, a.mem_addr, addr[11:2]);
      if (we) check({tag, ".mem_wdata"}, a.mem_wdata, exp_wdata);
    end
    a.ls_req = 1'b0;
    n = 0;
    en_seen = 0;
    do begin
      @(negedge clk);
      n++;
      if (a.mem_en) en_seen = 1;
    end while (!a.ls_rvalid && n < 20);
    check({tag, ".latency"}, n, exp_err ? 1 : 2);
    check({tag, ".err"}, a.ls_err, exp_err);
    check({tag, ".rdata"}, a.ls_rdata, exp_rdata);
    check({tag, ".if_rvalid"}, a.if_rvalid, 0);
    check({tag, ".no_late_en"}, en_seen, 0);
    @(negedge clk);
    check({tag, ".rvalid_once"}, a.ls_rvalid, 0);
    check({tag, ".idle"}, a.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_order;
    int n;
    int g;
    int rv;
    rst_a = 1'b1; rst_b = 1'b1;
    pl_a_en = 1'b0; pl_b_en = 1'b0; pl_addr = '0; pl_data = '0;
    a.if_req = 1'b0; a.if_addr = '0; a.ls_req = 1'b0; a.ls_we = 1'b0;
    a.ls_funct3 = '0; a.ls_addr = '0; a.ls_wdata = '0;
    b.if_req = 1'b0; b.if_addr = '0; b.ls_req = 1'b0; b.ls_we = 1'b0;
    b.ls_funct3 = '0; b.ls_addr = '0; b.ls_wdata = '0;

    preload(1'b0, 10'd4, 32'hDEAD_BEEF);
    preload(1'b0, 10'd0, 32'h8011_2233);
    preload(1'b0, 10'd1, 32'h0000_0000);
    preload(1'b0, 10'd2, 32'h0000_0000);
    preload(1'b1, 10'd5, 32'h1234_5678);
    preload(1'b1, 10'd2, 32'h0BAD_F00D);

    check("rst.busy", a.busy, 0);
    check("rst.mem_en", a.mem_en, 0);
    check("rst.if_gnt", a.if_gnt, 0);
    check("rst.if_rdata", a.if_rdata, 0);
    check("rst.ls_rdata", a.ls_rdata, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // IF fetch, MEM_LAT=1
    a.if_req = 1'b1; a.if_addr = 32'h10;
    @(negedge clk);
    check("if.gnt", a.if_gnt, 1);
    check("if.ls_gnt", a.ls_gnt, 0);
    check("if.mem_en", a.mem_en, 1);
    check("if.mem_addr", a.mem_addr, 4);
    check("if.mem_we", a.mem_we, 0);
    check("if.mem_be", a.mem_be, 4'hF);
    a.if_req = 1'b0;
    @(negedge clk);
    check("if.rvalid_early", a.if_rvalid, 0);
    check("if.mem_en_wait", a.mem_en, 0);
    @(negedge clk);
    check("if.rvalid", a.if_rvalid, 1);
    check("if.rdata", a.if_rdata, 32'hDEAD_BEEF);
    check("if.ls_rvalid", a.ls_rvalid, 0);
    @(negedge clk);
    check("if.rvalid_once", a.if_rvalid, 0);
    check("if.rdata_hold", a.if_rdata, 32'hDEAD_BEEF);
    check("if.idle", a.busy, 0);

    // Stores and loads
    ls_op("sb",  1'b1, F3_B,  32'h6, 32'h0000_00A5, 1'b0, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    check("sb.ram", ram_a[1], 32'h00A5_0000);
    ls_op("lb",  1'b0, F3_B,  32'h3, 32'h0, 1'b0, 4'hF, 32'h0, 32'hFFFF_FF80);
    ls_op("lbu", 1'b0, F3_BU, 32'h3, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0000_0080);
    ls_op("lh",  1'b0, F3_H,  32'h2, 32'h0, 1'b0, 4'hF, 32'h0, 32'hFFFF_8011);
    ls_op("lhu", 1'b0, F3_HU, 32'h2, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0000_8011);
    ls_op("lb1", 1'b0, F3_B,  32'h1, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0000_0022);
    ls_op("lw",  1'b0, F3_W,  32'h0, 32'h0, 1'b0, 4'hF, 32'h0, 32'h8011_2233);
    ls_op("sh",  1'b1, F3_H,  32'h2, 32'hBEEF_1234, 1'b0, 4'b1100, 32'h1234_1234, 32'h0);
    check("sh.ram", ram_a[0], 32'h1234_2233);
    ls_op("sw",  1'b1, F3_W,  32'h8, 32'hCAFE_F00D, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0);
    check("sw.ram", ram_a[2], 32'hCAFE_F00D);

    // Illegal accesses never strobe the RAM
    ls_op("sw_mis", 1'b1, F3_W,   32'h2, 32'hFFFF_FFFF, 1'b1, 4'h0, 32'h0, 32'h0);
    ls_op("lh_mis", 1'b0, F3_H,   32'h1, 32'h0,         1'b1, 4'h0, 32'h0, 32'h0);
    ls_op("st_100", 1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 1'b1, 4'h0, 32'h0, 32'h0);
    ls_op("ld_011", 1'b0, 3'b011, 32'h0, 32'h0,         1'b1, 4'h0, 32'h0, 32'h0);
    check("err.ram0", ram_a[0], 32'h1234_2233);
    check("err.ram0_w", ram_a[0], 32'h1234_2233);

    // Starvation bound: both requesters held high
    exp_order = 10'b10_0001_0000;
    a.ls_req = 1'b1; a.ls_we = 1'b0; a.ls_funct3 = F3_W; a.ls_addr = 32'h0;
    a.if_req = 1'b1; a.if_addr = 32'h10;
    g = 0; n = 0;
    while (g < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (a.if_rvalid && a.ls_rvalid) check("starve.dual_rvalid", 1, 0);
      if (a.if_gnt || a.ls_gnt) begin
        check($sformatf("starve.g%0d_if", g), a.if_gnt, exp_order[g]);
        check($sformatf("starve.g%0d_ls", g), a.ls_gnt, !exp_order[g]);
        g++;
      end
    end
    check("starve.count", g, 10);
    a.ls_req = 1'b0; a.if_req = 1'b0;
    n = 0;
    while (a.busy && n < 20) begin @(negedge clk); n++; end
    check("starve.drain", a.busy, 0);

    // MEM_LAT=3: reset during WAIT drops the load
    b.ls_req = 1'b1; b.ls_we = 1'b0; b.ls_funct3 = F3_W; b.ls_addr = 32'h8;
    n = 0;
    @(negedge clk);
    while (!b.ls_gnt && n < 20) begin @(negedge clk); n++; end
    check("rstb.gnt", b.ls_gnt, 1);
    b.ls_req = 1'b0;
    @(negedge clk);
    check("rstb.busy_wait", b.busy, 1);
    rst_b = 1'b1;
    #1;
    check("rstb.busy", b.busy, 0);
    check("rstb.ls_rvalid", b.ls_rvalid, 0);
    check("rstb.mem_en", b.mem_en, 0);
    check("rstb.ls_rdata", b.ls_rdata, 0);
    check("rstb.if_rdata", b.if_rdata, 0);
    @(negedge clk);
    rst_b = 1'b0;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (b.ls_rvalid) rv++;
    end
    check("rstb.no_rvalid", rv, 0);

    b.if_req = 1'b1; b.if_addr = 32'h14;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (b.if_gnt) b.if_req = 1'b0;
    end while (!b.if_rvalid && n < 20);
    check("rstb.if_latency", n, 5);
    check("rstb.if_rdata", b.if_rdata, 32'h1234_5678);
    check("rstb.ls_quiet", b.ls_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
